// File: rtl/aoi_bist_pkg.sv
// Shared definitions for the AOI BIST controller: FSM states, vector count,
// MISR polynomial and the golden AOI response.
package aoi_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int          NUM_VEC   = 32;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // x[4]=x_in1 .. x[0]=x_in5
    function automatic logic aoi_golden(input logic [4:0] x);
        return ~((x[4] & x[3]) | (x[2] & x[1]) | x[0]);
    endfunction

endpackage

// File: rtl/aoi_misr16.sv
// 16-bit Galois MISR (x^16+x^12+x^5+1), one shift per enable, din folded into feedback.
// clear reloads SEED synchronously; rst_n reloads it asynchronously.
module aoi_misr16
    import aoi_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic fb;

    assign fb = sig[15] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (clear) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/aoi_bist_ctrl.sv
// Exhaustive 32-vector BIST for a 5-input AOI gate; each vector takes SETTLE_CYC+1 cycles.
// Optional response signature enabled by macro AOI_BIST_SIG_EN (otherwise sig is tied to zero).
module aoi_bist_ctrl
    import aoi_bist_pkg::*;
#(
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] SIG_SEED   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  x_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_cnt,
    output logic [4:0]  first_err_vec,
    output logic [15:0] sig
);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       mismatch;

    assign accept   = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign mismatch = (y_in != aoi_golden(x_out));
    assign pass     = done && (err_cnt == 6'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            x_out         <= 5'd0;
            settle_cnt    <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= 6'd0;
            first_err_vec <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_SETTLE;
                        x_out         <= 5'd0;
                        settle_cnt    <= 4'd0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_cnt       <= 6'd0;
                        first_err_vec <= 5'd0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
                        state      <= S_SAMPLE;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 6'd1;
                        if (err_cnt == 6'd0) begin
                            first_err_vec <= x_out;
                        end
                    end
                    if (x_out == 5'(NUM_VEC - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        x_out <= x_out + 5'd1;
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AOI_BIST_SIG_EN
    aoi_misr16 #(
        .SEED (SIG_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (state == S_SAMPLE),
        .din   (y_in),
        .sig   (sig)
    );
`else
    logic [15:0] unused_seed;
    logic        unused_accept;

    assign unused_seed   = SIG_SEED;
    assign unused_accept = accept;
    assign sig           = 16'h0000;
`endif

endmodule

// File: tb/tb_aoi_bist_ctrl.sv
// Directed runs of aoi_bist_ctrl with response faults; expected results are queued per run
// and compared by a done-edge monitor.
module tb_aoi_bist_ctrl;

    typedef struct {
        int         run_id;
        logic [5:0] err;
        logic [4:0] fev;
        logic       pass;
        int         acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  x_out;
    logic        y_in;
    logic        busy, done, pass;
    logic [5:0]  err_cnt;
    logic [4:0]  first_err_vec;
    logic [15:0] sig;

    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   mode = 0;
    logic done_q = 1'b0;
    exp_t sb[$];
    logic [15:0] sig_log [0:7];

`ifdef AOI_BIST_SIG_EN
    localparam logic [15:0] RST_SIG = 16'hFFFF;
`else
    localparam logic [15:0] RST_SIG = 16'h0000;
`endif

    aoi_bist_ctrl #(
        .SETTLE_CYC (2),
        .SIG_SEED   (16'hFFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .x_out         (x_out),
        .y_in          (y_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_vec (first_err_vec),
        .sig           (sig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truth-table form of the AOI: output high only when x5=0 and neither AND pair is full.
    function automatic logic ref_aoi(input logic [4:0] v);
        if (v[0]) return 1'b0;
        if (v[4] && v[3]) return 1'b0;
        if (v[2] && v[1]) return 1'b0;
        return 1'b1;
    endfunction

    always_comb begin
        y_in = ref_aoi(x_out);
        case (mode)
            1: y_in = 1'b1;
            2: y_in = 1'b0;
            3: y_in = ~ref_aoi(x_out);
            4: y_in = (x_out == 5'd5) ? ~ref_aoi(x_out) : ref_aoi(x_out);
            default: y_in = ref_aoi(x_out);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rising done pops one expected run result.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("run%0d_err_cnt", e.run_id), 32'(err_cnt), 32'(e.err));
                chk($sformatf("run%0d_first_err_vec", e.run_id), 32'(first_err_vec), 32'(e.fev));
                chk($sformatf("run%0d_pass", e.run_id), 32'(pass), 32'(e.pass));
                chk($sformatf("run%0d_latency", e.run_id), 32'(cyc - e.acc_cyc), 32'd96);
                chk($sformatf("run%0d_busy_low", e.run_id), 32'(busy), 32'd0);
`ifndef AOI_BIST_SIG_EN
                chk($sformatf("run%0d_sig_zero", e.run_id), 32'(sig), 32'd0);
`endif
                sig_log[e.run_id] = sig;
            end
        end
        done_q <= done;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x_out"}, 32'(x_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first_err_vec"}, 32'(first_err_vec), 32'd0);
        chk({tag, "_sig"}, 32'(sig), 32'(RST_SIG));
    endtask

    task automatic do_run(input int id, input int m, input logic [5:0] e_err,
                          input logic [4:0] e_fev, input logic e_pass, input int restart_at);
        exp_t e;
        int   acc;
        logic seen;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        acc = cyc + 1;
        e.run_id = id; e.err = e_err; e.fev = e_fev; e.pass = e_pass; e.acc_cyc = acc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            start = (restart_at > 0) && (cyc - acc == restart_at - 1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk($sformatf("run%0d_done_seen", id), 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk($sformatf("run%0d_hold_x_out", id), 32'(x_out), 32'd31);
        chk($sformatf("run%0d_hold_done", id), 32'(done), 32'd1);
        chk($sformatf("run%0d_hold_err", id), 32'(err_cnt), 32'(e_err));
    endtask

    initial begin
        int acc;
        #2;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_release_busy", 32'(busy), 32'd0);
        chk("idle_after_release_x", 32'(x_out), 32'd0);

        do_run(0, 0, 6'd0,  5'd0, 1'b1, 0);
        do_run(1, 1, 6'd23, 5'd1, 1'b0, 0);
        do_run(2, 2, 6'd9,  5'd0, 1'b0, 0);
        do_run(3, 3, 6'd32, 5'd0, 1'b0, 0);
        do_run(4, 0, 6'd0,  5'd0, 1'b1, 40);
        do_run(5, 4, 6'd1,  5'd5, 1'b0, 0);

        // Mid-run reset at cycle 50 after accept.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - acc < 49) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        chk("midrun_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        chk("post_rst_idle_done", 32'(done), 32'd0);
        chk("post_rst_idle_x", 32'(x_out), 32'd0);

`ifdef AOI_BIST_SIG_EN
        chk("sig_repeatable", 32'(sig_log[4]), 32'(sig_log[0]));
        chk("sig_nonzero", 32'(sig_log[0] != 16'h0000), 32'd1);
        chk("sig_flip_differs", 32'(sig_log[5] != sig_log[0]), 32'd1);
`endif
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
